// File: rtl/seg7_pkg.sv
// Shared types, constants and helpers for the seven-segment scan driver.
package seg7_pkg;

  // Active-low {g..a} patterns for an unlit digit and for the overflow dash.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CONVERT,
    COMMIT
  } state_e;

  // Bits needed to hold a counter that runs 0..n-1 (at least one bit).
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hex nibble to active-low segment pattern {g..a}.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per clock, DATA_W clocks per
// conversion. Reports the low NUM_DIGITS BCD digits plus an overflow flag when
// any higher decimal digit is nonzero.
module bin2bcd_seq import seg7_pkg::*; #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    overflow_o
);

  // Every 3 binary bits add at most one decimal digit, so this always fits.
  localparam int NUM_BCD    = (DATA_W + 2) / 3;
  localparam int BCD_DIGITS = (NUM_BCD > NUM_DIGITS) ? NUM_BCD : NUM_DIGITS;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int ITER_W     = width_of(DATA_W);

  logic [BCD_W-1:0]  bcd_q, bcd_d, bcd_adj;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              run_q, run_d;
  logic              last_iter;

  // Add-3 correction on every BCD nibble that would exceed 9 after the shift.
  for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
  end

  assign last_iter = (iter_q == ITER_W'(DATA_W - 1));

  // Next state: load on start, otherwise one correct-and-shift step while running.
  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    iter_d = iter_q;
    run_d  = run_q;
    if (start_i) begin
      bcd_d  = '0;
      bin_d  = bin_i;
      iter_d = '0;
      run_d  = 1'b1;
    end else if (run_q) begin
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      iter_d         = iter_q + 1'b1;
      if (last_iter) begin
        run_d = 1'b0;
      end
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      iter_q <= iter_d;
      run_q  <= run_d;
    end
  end

  // High while the final shift is happening; the result is stable next cycle.
  assign done_o = run_q && last_iter;
  assign bcd_o  = bcd_q[4*NUM_DIGITS-1:0];

  if (BCD_DIGITS > NUM_DIGITS) begin : g_ovf
    assign overflow_o = |bcd_q[BCD_W-1:4*NUM_DIGITS];
  end else begin : g_no_ovf
    assign overflow_o = 1'b0;
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed N-digit common-anode seven-segment driver. Loads a binary value,
// renders it as hex or decimal, blanks leading zeros on request and scans one
// digit at a time. The displayed digits only change atomically on COMMIT.
module seven_segment_scan_driver import seg7_pkg::*; #(
  parameter int DATA_W      = 16,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  value_valid,
  input  logic                  mode,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy
);

  localparam int IDX_W = width_of(NUM_DIGITS);
  localparam int CNT_W = width_of(REFRESH_DIV);
  localparam int HEX_W = 4 * NUM_DIGITS;

  state_e                state_q;
  logic [DATA_W-1:0]     load_val_q, work_val_q;
  logic                  load_mode_q, work_mode_q, pend_q;
  logic [HEX_W-1:0]      digits_q;
  logic                  ovf_q, busy_q;
  logic [CNT_W-1:0]      refresh_q;
  logic [IDX_W-1:0]      idx_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  conv_start, conv_done, bcd_ovf, hex_ovf;
  logic [HEX_W-1:0]      bcd_digits, hex_digits;
  logic [NUM_DIGITS-1:0] blank_vec;

  // The converter is kicked off from CAPTURE with the value being captured.
  assign conv_start = (state_q == CAPTURE) && !load_mode_q;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk        (clk),
    .reset      (reset),
    .start_i    (conv_start),
    .bin_i      (load_val_q),
    .done_o     (conv_done),
    .bcd_o      (bcd_digits),
    .overflow_o (bcd_ovf)
  );

  // Hex rendering is just the low nibbles; anything above them is overflow.
  if (DATA_W > HEX_W) begin : g_hex_trunc
    assign hex_digits = work_val_q[HEX_W-1:0];
    assign hex_ovf    = |work_val_q[DATA_W-1:HEX_W];
  end else begin : g_hex_ext
    assign hex_digits = HEX_W'(work_val_q);
    assign hex_ovf    = 1'b0;
  end

  // Load sequencing: latest value_valid wins, loads during a conversion queue up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_val_q  <= '0;
      load_mode_q <= 1'b0;
      pend_q      <= 1'b0;
      work_val_q  <= '0;
      work_mode_q <= 1'b0;
      digits_q    <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (value_valid) begin
        load_val_q  <= value;
        load_mode_q <= mode;
      end
      unique case (state_q)
        IDLE: begin
          if (value_valid) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          work_val_q  <= load_val_q;
          work_mode_q <= load_mode_q;
          pend_q      <= value_valid;
          busy_q      <= 1'b1;
          state_q     <= load_mode_q ? COMMIT : CONVERT;
        end
        CONVERT: begin
          if (value_valid) begin
            pend_q <= 1'b1;
          end
          if (conv_done) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          digits_q <= work_mode_q ? hex_digits : bcd_digits;
          ovf_q    <= work_mode_q ? hex_ovf : bcd_ovf;
          busy_q   <= 1'b0;
          pend_q   <= 1'b0;
          state_q  <= (pend_q || value_valid) ? CAPTURE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Digit k (k>0) is a leading zero when it and every digit above it are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
    if (gi == 0) begin : g_units
      assign blank_vec[gi] = 1'b0;
    end else begin : g_upper
      assign blank_vec[gi] = blank_lz && (digits_q[HEX_W-1:4*gi] == '0);
    end
  end

  // Refresh timer and digit index; the index advances when the timer wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_q <= '0;
      idx_q     <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  // Select the anode and segment pattern for the digit being scanned.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        an_d[k] = 1'b0;
        if (ovf_q) begin
          seg_d = SEG_DASH;
        end else if (blank_vec[k]) begin
          seg_d = SEG_BLANK;
        end else begin
          seg_d = glyph(digits_q[4*k +: 4]);
        end
      end
    end
  end

  // Anode and segment outputs register together so they switch in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = busy_q;
  assign dp   = 1'b1;

endmodule
